// File: rtl/not_gate_pkg.sv
// -----------------------------------------------------------------------------
// not_gate_pkg
//
// Shared definitions for the not_gate_bank slice:
//   - state_e  : reload FSM states of the top level (RUN, DRAIN, LOAD).
//   - all_ones : builds an all-ones constant of a given width. It supplies the
//                default polarity mask, so the bank is a plain inverter array
//                out of reset.
// -----------------------------------------------------------------------------
package not_gate_pkg;

    // Widest bank the slice supports. all_ones() returns a vector of this size.
    localparam int MAX_WIDTH = 64;

    // Mask-reload sequencing states.
    //   ST_RUN   : normal streaming; a reload request moves to ST_DRAIN.
    //   ST_DRAIN : input blocked until the output register is empty.
    //   ST_LOAD  : one-cycle capture of the new mask (cfg_ready high).
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Returns a MAX_WIDTH-bit vector with the low `width` bits set.
    // Callers cast the result down to their own width.
    function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage : not_gate_pkg

// File: rtl/not_gate_stage.sv
// -----------------------------------------------------------------------------
// not_gate_stage
//
// Single valid/ready register stage. It holds one word and sustains one
// word per cycle when the consumer keeps out_ready high.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (clears data and valid)
//   en         in   upstream acceptance enable; when 0 the stage refuses new
//                   words but can still deliver the word it holds
//   din        in   WIDTH  word to capture
//   in_valid   in   din is valid
//   in_ready   out  stage accepts din this cycle (combinational)
//   dout       out  WIDTH  held word
//   out_valid  out  dout is valid
//   out_ready  in   consumer accepts dout
// -----------------------------------------------------------------------------
module not_gate_stage #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] data_d,  data_q;
    logic             valid_d, valid_q;
    logic             xfer_in;
    logic             xfer_out;

    // A slot is free when the register is empty or its word leaves this
    // same cycle, which is what gives back-to-back throughput.
    assign in_ready = en & (~valid_q | out_ready);

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = valid_q & out_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (xfer_in) begin
            // New word replaces any word departing this cycle.
            data_d  = din;
            valid_d = 1'b1;
        end else if (xfer_out) begin
            valid_d = 1'b0;
        end
        // Otherwise hold: covers both idle and stalled (valid & !ready).
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign dout      = data_q;
    assign out_valid = valid_q;

endmodule : not_gate_stage

// File: rtl/not_gate_bank.sv
// -----------------------------------------------------------------------------
// not_gate_bank
//
// WIDTH-channel registered inverter bank with a runtime polarity mask.
// Each output bit is din XOR mask: a mask bit of 1 inverts that channel,
// 0 passes it through. Data flows through one valid/ready stage with a
// latency of one cycle.
//
// The mask is reloaded through a separate handshake. To keep every word
// consistent, a reload first blocks new input and waits for the output
// register to empty, then captures cfg_mask in a single LOAD cycle. The
// first word accepted after LOAD uses the new mask.
//
// Ports:
//   sys_clk    in   clock, rising edge
//   sys_rst    in   synchronous active-high reset
//   din        in   WIDTH  input word
//   in_valid   in   din is valid
//   in_ready   out  din accepted this cycle (0 during reset, DRAIN, LOAD)
//   dout       out  WIDTH  registered din ^ mask
//   out_valid  out  dout is valid
//   out_ready  in   consumer accepts dout
//   cfg_mask   in   WIDTH  new mask, stable while cfg_valid is high
//   cfg_valid  in   reload request
//   cfg_ready  out  one-cycle pulse in the cycle cfg_mask is captured
//   mask_q     out  WIDTH  active mask
// -----------------------------------------------------------------------------
module not_gate_bank
    import not_gate_pkg::*;
#(
    parameter int               WIDTH    = 15,
    parameter logic [WIDTH-1:0] DEF_MASK = WIDTH'(all_ones(WIDTH))
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic [WIDTH-1:0] mask_q
);

    state_e           state_d, state_q;
    logic             cfg_ready_d, cfg_ready_q;
    logic [WIDTH-1:0] mask_d;
    logic             stage_en;
    logic [WIDTH-1:0] stage_din;

    // Input is only taken while streaming and never while reset is asserted.
    assign stage_en  = (state_q == ST_RUN) & ~sys_rst;

    // Polarity is applied on the way in, so the held word already carries
    // the mask that was active when it was accepted.
    assign stage_din = din ^ mask_q;

    not_gate_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .en        (stage_en),
        .din       (stage_din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reload sequencing. cfg_ready is registered: it is set on the edge that
    // enters LOAD, so it is high for exactly the LOAD cycle.
    always_comb begin
        state_d     = state_q;
        cfg_ready_d = 1'b0;
        mask_d      = mask_q;
        unique case (state_q)
            ST_RUN: begin
                // A word accepted in this same cycle still uses the old mask.
                if (cfg_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!cfg_valid) begin
                    // Request withdrawn before capture: resume, mask unchanged.
                    state_d = ST_RUN;
                end else if (!out_valid || out_ready) begin
                    // Output empty now, or its last word leaves on this edge.
                    state_d     = ST_LOAD;
                    cfg_ready_d = 1'b1;
                end
            end
            ST_LOAD: begin
                mask_d  = cfg_mask;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_RUN;
            cfg_ready_q <= 1'b0;
            mask_q      <= DEF_MASK;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            mask_q      <= mask_d;
        end
    end

    assign cfg_ready = cfg_ready_q;

endmodule : not_gate_bank

// File: doc/not_gate_bank.md
Name: not_gate_bank

Overview:
- Parametrised successor to the fixed 15-input inverter array.
- WIDTH-bit registered inverter bank with a runtime per-bit polarity mask: mask bit 1 inverts that bit, mask bit 0 passes it through.
- Data moves through a valid/ready pipeline stage. The mask is reloaded through its own handshake and applied atomically: the pipeline is drained first, so no in-flight word ever sees a mixed mask.
- Sits between input-pin capture logic and downstream consumers in the same board designs.

Parameters:
- WIDTH, 15, number of channels (1..64).
- DEF_MASK, {WIDTH{1'b1}}, mask value after reset; all-ones gives pure NOT-gate behaviour.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  input data word.
- in_valid  input  1  din is valid.
- in_ready  output  1  block accepts din this cycle.
- dout  output  WIDTH  registered result, din XOR mask.
- out_valid  output  1  dout is valid.
- out_ready  input  1  downstream accepts dout.
- cfg_mask  input  WIDTH  new polarity mask; held stable while cfg_valid=1.
- cfg_valid  input  1  mask update request.
- cfg_ready  output  1  one-cycle pulse; cfg_mask is captured in this cycle.
- mask_q  output  WIDTH  currently active mask.

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - dout=0, out_valid=0, cfg_ready=0, mask_q=DEF_MASK, state=RUN.
  - in_ready is 0 during reset.
  - Reset mid-transfer or mid-reload discards the held word and any pending reload.
- Transfers:
  - Input transfer: in_valid & in_ready at an edge.
  - Output transfer: out_valid & out_ready at an edge.
- Datapath:
  - On an input transfer, dout <= din ^ mask_q, out_valid <= 1. Latency is 1 cycle.
  - In RUN, in_ready = !out_valid | out_ready (combinational). This gives full throughput of 1 word/cycle under continuous out_ready.
  - Output transfer with no simultaneous input transfer: out_valid <= 0.
  - Simultaneous input and output transfer: the new word replaces the old one; out_valid stays 1.
  - While out_valid=1 and out_ready=0, dout and out_valid hold unchanged.
- FSM states: RUN, DRAIN, LOAD.
  - RUN: datapath as above. If cfg_valid=1, go to DRAIN next cycle. Any input transfer in that same cycle still completes with the old mask.
  - DRAIN: in_ready=0. Stay while out_valid=1 and out_ready=0. Go to LOAD when out_valid=0, or when an output transfer occurs this cycle.
  - LOAD: in_ready=0, cfg_ready=1 for exactly one cycle, mask_q <= cfg_mask; next state RUN.
  - If cfg_valid drops before LOAD, return from DRAIN to RUN without loading. cfg_ready stays 0.
- cfg_ready is never high outside LOAD. A cfg_valid held high after the LOAD pulse starts a new reload cycle.
- The first word accepted after LOAD uses the new mask. Minimum reload cost with an empty pipeline: 2 cycles of in_ready=0.
- No arithmetic; XOR is bitwise, with no width growth.

Decomposition:
- Package not_gate_pkg holds:
  - state enum (RUN, DRAIN, LOAD) as a 2-bit typedef;
  - function all_ones(width) used for the DEF_MASK default.
- One natural sub-module: not_gate_stage, the single valid/ready register stage (data, valid, ready logic, hold-on-stall).
- The FSM and mask register live in the top level.

Test Plan:
- Default inversion: after reset, din=15'h1234, in_valid=1, out_ready=1 -> next cycle dout=15'h6DCB, out_valid=1, mask_q=15'h7FFF.
- Back-to-back throughput: 8 words 0..7 streamed with out_ready=1 -> dout = 15'h7FFF..15'h7FF8 on consecutive cycles, in_ready never drops.
- Backpressure: out_ready=0 for 5 cycles with a word held -> dout and out_valid stable, in_ready=0; release -> word delivered once, no duplicate or loss.
- Mask reload: cfg_mask=15'h0000, cfg_valid=1 with the pipeline empty -> cfg_ready pulses 2 cycles later; then din=15'h1234 -> dout=15'h1234.
- Reload under stall: word pending, out_ready=0, cfg_valid=1 -> state holds DRAIN, cfg_ready=0; out_ready=1 -> old-mask word is delivered, then the LOAD pulse, and new words use the new mask.
- Reset mid-operation: assert sys_rst during DRAIN with a word held -> next cycle out_valid=0, dout=0, mask_q=15'h7FFF, cfg_ready=0.
